// File: rtl/fifo_sum_pkg.sv
// fifo_sum_pkg
// Shared definitions for the FIFO row-sum controller: FSM state encoding,
// default matrix geometry, datapath widths and the wrapped row-sum helper.
package fifo_sum_pkg;

    localparam int DATA_W   = 8;   // UART / FIFO byte width
    localparam int SUM_W    = 10;  // wide enough for three bytes (max 765)
    localparam int DEF_COLS = 5;   // bytes per matrix row
    localparam int DEF_ROWS = 5;   // rows per frame (>= 3)

    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        EMIT
    } state_t;

    // Counter width for a counter running 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Three-byte column sum formed at full width, then reduced modulo 256:
    // the transmitted byte wraps rather than saturating.
    function automatic byte_t row_sum(input byte_t a, input byte_t b, input byte_t x);
        return DATA_W'(SUM_W'(a) + SUM_W'(b) + SUM_W'(x));
    endfunction

endpackage

// File: rtl/fifo_sum_ctrl_if.sv
// fifo_sum_ctrl_if
// Bundles the controller's data-path connections:
//   rx_data/rx_valid        byte stream from the UART receiver
//   fifo1_*/fifo2_*         write and read ports of the two row FIFOs
//   tx_busy/tx_start/tx_data handshake with the UART transmitter
// master: the controller side.  slave: the surrounding RX/FIFO/TX blocks.
interface fifo_sum_ctrl_if;
    import fifo_sum_pkg::*;

    byte_t rx_data;
    logic  rx_valid;

    logic  fifo1_wr_en;
    byte_t fifo1_wr_data;
    logic  fifo1_rd_en;
    byte_t fifo1_rd_data;

    logic  fifo2_wr_en;
    byte_t fifo2_wr_data;
    logic  fifo2_rd_en;
    byte_t fifo2_rd_data;

    logic  tx_busy;
    logic  tx_start;
    byte_t tx_data;

    modport master (
        input  rx_data, rx_valid,
        input  fifo1_rd_data, fifo2_rd_data,
        input  tx_busy,
        output fifo1_wr_en, fifo1_wr_data, fifo1_rd_en,
        output fifo2_wr_en, fifo2_wr_data, fifo2_rd_en,
        output tx_start, tx_data
    );

    modport slave (
        output rx_data, rx_valid,
        output fifo1_rd_data, fifo2_rd_data,
        output tx_busy,
        input  fifo1_wr_en, fifo1_wr_data, fifo1_rd_en,
        input  fifo2_wr_en, fifo2_wr_data, fifo2_rd_en,
        input  tx_start, tx_data
    );

endinterface

// File: rtl/sum_tx_buf.sv
// sum_tx_buf
// One-entry holding register between the sum datapath and the UART TX.
//   sys_clk, rst_n  clock, asynchronous active-low reset
//   push, push_data new sum byte offered (one cycle)
//   tx_busy         UART transmitter busy
//   tx_start        one-cycle start strobe, tx_data valid with it
//   tx_data         byte handed to the transmitter (holds last value)
//   empty           no byte waiting
//   overflow        a pushed byte was dropped this cycle (buffer full, TX busy)
module sum_tx_buf
    import fifo_sum_pkg::*;
(
    input  logic  sys_clk,
    input  logic  rst_n,
    input  logic  push,
    input  byte_t push_data,
    input  logic  tx_busy,
    output logic  tx_start,
    output byte_t tx_data,
    output logic  empty,
    output logic  overflow
);

    logic  full;
    byte_t buf_q;
    logic  launch_old;

    // A waiting byte leaves as soon as the transmitter is free; that frees
    // the slot in the same edge, so a simultaneous push is still accepted.
    assign launch_old = full && !tx_busy;
    assign empty      = !full;
    assign overflow   = push && full && tx_busy;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            // NOTE: data registers are reset too so every output has a defined value out of reset.
            buf_q    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the default below makes tx_start a single-cycle pulse.
            tx_start <= 1'b0;
            if (launch_old) begin
                tx_start <= 1'b1;
                tx_data  <= buf_q;
                full     <= push;
                if (push) begin
                    buf_q <= push_data;
                end
            end else if (!full && push) begin
                if (!tx_busy) begin
                    // Empty buffer and idle transmitter: bypass straight out.
                    tx_start <= 1'b1;
                    tx_data  <= push_data;
                end else begin
                    full  <= 1'b1;
                    buf_q <= push_data;
                end
            end
            // full && tx_busy && push: new byte is dropped, overflow reports it.
        end
    end

endmodule

// File: rtl/fifo_sum_ctrl.sv
// fifo_sum_ctrl
// Sequencing controller for the FIFO row-sum datapath. Rows 0 and 1 of each
// frame are parked in FIFO1 and FIFO2; every later byte x is summed with the
// matching bytes of the two previous rows (a from FIFO1, b from FIFO2), the
// window is rolled (b -> FIFO1, x -> FIFO2) and sum mod 256 is sent to TX.
//   sys_clk, rst_n  clock, asynchronous active-low reset
//   bus             fifo_sum_ctrl_if.master: RX stream, both FIFOs, UART TX
//   busy_flag       frame in progress (until the last sum has left)
//   err             sticky: input byte dropped outside IDLE, or sum dropped
module fifo_sum_ctrl
    import fifo_sum_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    fifo_sum_ctrl_if.master bus,
    output logic            busy_flag,
    output logic            err
);

    localparam int COL_W = cnt_w(COLS);
    localparam int ROW_W = cnt_w(ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    byte_t            x_q;
    byte_t            sum_q;
    byte_t            wr_data_q;
    logic             wr1_q;
    logic             wr2_q;
    logic             rd_en_q;
    logic             wb_q;        // current byte's row is not the last one
    logic             cap_wb_q;    // high exactly during a writeback CAPTURE
    logic             frame_end_q; // last byte accepted, waiting for TX drain

    logic             accept;
    logic             drop_rx;
    logic             push;
    logic             buf_empty;
    logic             overflow;
    logic             tx_start;
    byte_t            tx_data;

    assign accept  = bus.rx_valid && (state == IDLE);
    assign drop_rx = bus.rx_valid && (state != IDLE);
    assign push    = (state == EMIT);

    // Row 0/1 writes come from registers. The rolling writeback needs
    // fifo2_rd_data, which is only valid during CAPTURE, so during that
    // cycle the write ports are steered by the registered cap_wb_q.
    assign bus.fifo1_wr_en   = wr1_q | cap_wb_q;
    assign bus.fifo2_wr_en   = wr2_q | cap_wb_q;
    assign bus.fifo1_wr_data = cap_wb_q ? bus.fifo2_rd_data : wr_data_q;
    assign bus.fifo2_wr_data = cap_wb_q ? x_q : wr_data_q;
    assign bus.fifo1_rd_en   = rd_en_q;
    assign bus.fifo2_rd_en   = rd_en_q;
    assign bus.tx_start      = tx_start;
    assign bus.tx_data       = tx_data;

    // Sequencing FSM with registered strobes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_q       <= '0;
            sum_q     <= '0;
            wr_data_q <= '0;
            wr1_q     <= 1'b0;
            wr2_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            wb_q      <= 1'b0;
            cap_wb_q  <= 1'b0;
        end else begin
            wr1_q    <= 1'b0;
            wr2_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            cap_wb_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (row == '0) begin
                            wr1_q     <= 1'b1;
                            wr_data_q <= bus.rx_data;
                        end else if (row == ROW_W'(1)) begin
                            wr2_q     <= 1'b1;
                            wr_data_q <= bus.rx_data;
                        end else begin
                            x_q     <= bus.rx_data;
                            wb_q    <= (row != ROW_LAST);
                            rd_en_q <= 1'b1;   // strobe is high during READ
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    cap_wb_q <= wb_q;          // last row drains the FIFOs
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    sum_q <= row_sum(bus.fifo1_rd_data, bus.fifo2_rd_data, x_q);
                    state <= EMIT;
                end
                EMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Position counters, frame tracking and sticky error.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            busy_flag   <= 1'b0;
            frame_end_q <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (drop_rx || overflow) begin
                err <= 1'b1;
            end
            if (accept) begin
                busy_flag <= 1'b1;
                if (row == '0 && col == '0) begin
                    frame_end_q <= 1'b0;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row         <= '0;
                        frame_end_q <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else if (frame_end_q && state == IDLE && buf_empty) begin
                // Last sum has been launched: frame complete.
                busy_flag   <= 1'b0;
                frame_end_q <= 1'b0;
            end
        end
    end

    sum_tx_buf u_tx_buf (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sum_q),
        .tx_busy   (bus.tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .empty     (buf_empty),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_fifo_sum_ctrl.sv
// tb_fifo_sum_ctrl
// Table-driven bench for fifo_sum_ctrl: each table record is one matrix
// column (five row bytes) with its three hand-computed output sums. Frames
// are streamed row-major; FIFOs and the UART TX busy behaviour are modelled.
module tb_fifo_sum_ctrl;
    import fifo_sum_pkg::*;

    localparam int COLS        = 5;
    localparam int ROWS        = 5;
    localparam int N_OUT       = (ROWS - 2) * COLS;
    localparam int RX_GAP      = 12;  // idle cycles between received bytes
    localparam int TX_BUSY_CYC = 8;   // transmitter busy time per byte

    typedef struct packed {
        logic [4:0][7:0] col_in;   // [row] input byte
        logic [2:0][7:0] exp_out;  // [row-2] expected TX byte
    } col_vec_t;

    logic     sys_clk = 1'b0;
    logic     rst_n   = 1'b0;
    logic     busy_flag;
    logic     err;
    logic     force_busy = 1'b0;
    int       cyc = 0;
    int       n_pass = 0;
    int       n_total = 0;
    col_vec_t tbl [10];

    fifo_sum_ctrl_if bus ();

    fifo_sum_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy_flag (busy_flag),
        .err       (err)
    );

    always #10 sys_clk = ~sys_clk;   // 50 MHz

    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- FIFO models (data valid the cycle after rd_en) -------
    byte_t f1_q[$];
    byte_t f2_q[$];
    byte_t f1_rd, f2_rd;
    int    fifo_err;

    assign bus.fifo1_rd_data = f1_rd;
    assign bus.fifo2_rd_data = f2_rd;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            f1_q.delete();
            f2_q.delete();
            f1_rd    <= '0;
            f2_rd    <= '0;
            fifo_err <= 0;
        end else begin
            if (bus.fifo1_rd_en) begin
                if (f1_q.size() == 0) fifo_err <= fifo_err + 1;
                else f1_rd <= f1_q.pop_front();
            end
            if (bus.fifo2_rd_en) begin
                if (f2_q.size() == 0) fifo_err <= fifo_err + 1;
                else f2_rd <= f2_q.pop_front();
            end
            if (bus.fifo1_wr_en) begin
                if (f1_q.size() >= COLS) fifo_err <= fifo_err + 1;
                else f1_q.push_back(bus.fifo1_wr_data);
            end
            if (bus.fifo2_wr_en) begin
                if (f2_q.size() >= COLS) fifo_err <= fifo_err + 1;
                else f2_q.push_back(bus.fifo2_wr_data);
            end
        end
    end

    // ---------------- UART TX model ----------------------------------------
    byte_t tx_q[$];
    int    tx_busy_cnt = 0;

    assign bus.tx_busy = force_busy | (tx_busy_cnt > 0);

    always @(negedge sys_clk) begin
        if (tx_busy_cnt > 0) tx_busy_cnt = tx_busy_cnt - 1;
        if (bus.tx_start) begin
            tx_q.push_back(bus.tx_data);
            tx_busy_cnt = TX_BUSY_CYC;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic col_vec_t mk(input byte_t r0, input byte_t r1, input byte_t r2,
                                    input byte_t r3, input byte_t r4,
                                    input byte_t e0, input byte_t e1, input byte_t e2);
        col_vec_t v;
        v.col_in[0]  = r0;
        v.col_in[1]  = r1;
        v.col_in[2]  = r2;
        v.col_in[3]  = r3;
        v.col_in[4]  = r4;
        v.exp_out[0] = e0;
        v.exp_out[1] = e1;
        v.exp_out[2] = e2;
        return v;
    endfunction

    // Returns at the falling edge of the cycle after rx_valid.
    task automatic send_byte(input byte_t d, output int rx_cyc);
        @(negedge sys_clk);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        rx_cyc       = cyc;
        @(negedge sys_clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_rows(input int base, input int r_lo, input int r_hi, input bit timing);
        int rx_cyc;
        int lat;
        for (int r = r_lo; r <= r_hi; r++) begin
            for (int c = 0; c < COLS; c++) begin
                send_byte(tbl[base + c].col_in[r], rx_cyc);
                if (timing) begin
                    if (r == 0 && c == 0) begin
                        check("row0_wr1_en", bus.fifo1_wr_en, 1);
                        check("row0_wr1_data", bus.fifo1_wr_data, tbl[base].col_in[0]);
                        check("busy_set", busy_flag, 1);
                    end
                    if (r == 1 && c == 0) begin
                        check("row1_wr2_en", bus.fifo2_wr_en, 1);
                        check("row1_wr1_quiet", bus.fifo1_wr_en, 0);
                    end
                    if (r == 2 && c == 0) begin
                        check("read_strobes", bus.fifo1_rd_en & bus.fifo2_rd_en, 1);
                        lat = -1;
                        repeat (8) begin
                            if (bus.tx_start && lat < 0) lat = cyc - rx_cyc;
                            @(negedge sys_clk);
                        end
                        check("emit_latency", lat, 4);
                    end
                    if (r == ROWS - 1 && c == COLS - 1) begin
                        check("busy_at_last_byte", busy_flag, 1);
                    end
                end
                idle(RX_GAP);
            end
        end
    endtask

    task automatic check_frame(input int base, input string tag, input int tx_base,
                               input logic exp_err);
        int k;
        int r;
        int c;
        logic [31:0] act;
        k = 0;
        while (busy_flag && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        check({tag, "_busy_fall"}, busy_flag, 0);
        check({tag, "_tx_count"}, tx_q.size() - tx_base, N_OUT);
        for (int i = 0; i < N_OUT; i++) begin
            r   = i / COLS;
            c   = i % COLS;
            act = (tx_base + i < tx_q.size()) ? 32'(tx_q[tx_base + i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_tx%0d", tag, i), act, tbl[base + c].exp_out[r]);
        end
        check({tag, "_err"}, err, exp_err);
        check({tag, "_fifo1_empty"}, f1_q.size(), 0);
        check({tag, "_fifo2_empty"}, f2_q.size(), 0);
        check({tag, "_fifo_seq"}, fifo_err, 0);
        check({tag, "_no_rd"}, bus.fifo1_rd_en | bus.fifo2_rd_en, 0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    // ---------------- test sequence ----------------------------------------
    initial begin
        int tb;
        int rx_cyc;

        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;

        // Frame A: rows {1..5},{31..35},{101..105},{31..35},{1..5}
        tbl[0] = mk(8'd1, 8'd31, 8'd101, 8'd31, 8'd1, 8'd133, 8'd163, 8'd133);
        tbl[1] = mk(8'd2, 8'd32, 8'd102, 8'd32, 8'd2, 8'd136, 8'd166, 8'd136);
        tbl[2] = mk(8'd3, 8'd33, 8'd103, 8'd33, 8'd3, 8'd139, 8'd169, 8'd139);
        tbl[3] = mk(8'd4, 8'd34, 8'd104, 8'd34, 8'd4, 8'd142, 8'd172, 8'd142);
        tbl[4] = mk(8'd5, 8'd35, 8'd105, 8'd35, 8'd5, 8'd145, 8'd175, 8'd145);
        // Frame B: wrap-around and extreme values
        tbl[5] = mk(8'd200, 8'd100, 8'd50, 8'd0, 8'd0, 8'd94, 8'd150, 8'd50);
        tbl[6] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd253, 8'd253, 8'd253);
        tbl[7] = mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        tbl[8] = mk(8'd255, 8'd1, 8'd0, 8'd255, 8'd1, 8'd0, 8'd0, 8'd0);
        tbl[9] = mk(8'd128, 8'd64, 8'd32, 8'd16, 8'd8, 8'd224, 8'd112, 8'd56);

        // Reset values
        idle(3);
        check("rst_busy", busy_flag, 0);
        check("rst_err", err, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_wr_en", {bus.fifo1_wr_en, bus.fifo2_wr_en}, 0);
        check("rst_rd_en", {bus.fifo1_rd_en, bus.fifo2_rd_en}, 0);
        check("rst_wr_data", {bus.fifo1_wr_data, bus.fifo2_wr_data}, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        idle(2);

        // Full frame with timing checks, then an identical second frame
        tb = tx_q.size();
        send_rows(0, 0, ROWS - 1, 1'b1);
        check_frame(0, "frame_a", tb, 1'b0);
        tb = tx_q.size();
        send_rows(0, 0, ROWS - 1, 1'b0);
        check_frame(0, "frame_a2", tb, 1'b0);

        // Wrap-around sums
        tb = tx_q.size();
        send_rows(5, 0, ROWS - 1, 1'b0);
        check_frame(5, "frame_b", tb, 1'b0);

        // TX held busy across two EMITs: second sum dropped
        do_reset();
        tb = tx_q.size();
        force_busy = 1'b1;
        send_rows(0, 0, 1, 1'b0);
        send_byte(tbl[0].col_in[2], rx_cyc);
        idle(RX_GAP);
        check("hold_err_before", err, 0);
        send_byte(tbl[1].col_in[2], rx_cyc);
        idle(RX_GAP);
        check("hold_err_after", err, 1);
        check("hold_no_start", tx_q.size() - tb, 0);
        force_busy = 1'b0;
        idle(20);
        check("hold_one_start", tx_q.size() - tb, 1);
        check("hold_byte", (tx_q.size() > tb) ? 32'(tx_q[tb]) : 32'hFFFF_FFFF, 133);

        // rx_valid during READ: byte ignored, frame still aligned
        do_reset();
        tb = tx_q.size();
        send_rows(0, 0, 1, 1'b0);
        @(negedge sys_clk);
        bus.rx_data  = tbl[0].col_in[2];
        bus.rx_valid = 1'b1;
        @(negedge sys_clk);
        bus.rx_data  = 8'd77;
        @(negedge sys_clk);
        bus.rx_valid = 1'b0;
        idle(RX_GAP);
        check("rx_in_read_err", err, 1);
        for (int c = 1; c < COLS; c++) begin
            send_byte(tbl[c].col_in[2], rx_cyc);
            idle(RX_GAP);
        end
        send_rows(0, 3, ROWS - 1, 1'b0);
        check_frame(0, "rx_in_read", tb, 1'b1);

        // Reset pulsed mid-row 2 (during READ), then a fresh frame
        send_rows(0, 0, 1, 1'b0);
        send_byte(tbl[0].col_in[2], rx_cyc);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_flag, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rd_en", {bus.fifo1_rd_en, bus.fifo2_rd_en}, 0);
        check("mid_rst_wr_en", {bus.fifo1_wr_en, bus.fifo2_wr_en}, 0);
        check("mid_rst_tx", {bus.tx_start, bus.tx_data}, 0);
        check("mid_rst_wr_data", {bus.fifo1_wr_data, bus.fifo2_wr_data}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        tb = tx_q.size();
        send_rows(0, 0, ROWS - 1, 1'b0);
        check_frame(0, "after_rst", tb, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
